// File: rtl/rom_dl_sequencer_if.sv
// rom_dl_sequencer_if: the two SDRAM write ports fed by the ROM download sequencer.
// Each port uses a toggle req/ack handshake; master drives req/a/ds/d, slave returns ack.
interface rom_dl_sequencer_if;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;

    modport master (
        output port1_req, port1_a, port1_ds, port1_d,
        output port2_req, port2_a, port2_ds, port2_d,
        input  port1_ack, port2_ack
    );

    modport slave (
        input  port1_req, port1_a, port1_ds, port1_d,
        input  port2_req, port2_a, port2_ds, port2_d,
        output port1_ack, port2_ack
    );
endinterface

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: buffers ioctl ROM bytes, writes them to SDRAM port1/port2, owns core reset.
// Optional macro DL_BOTH_PORTS_EN: mirror every byte onto both ports instead of region routing.
module rom_dl_sequencer #(
    parameter logic [24:0] SP_BASE   = 25'h12000,
    parameter logic [7:0]  DL_INDEX  = 8'h00,
    parameter int          FIFO_LOG2 = 2,
    parameter logic [15:0] RST_HOLD  = 16'hFFFF
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ioctl_downl,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    input  logic               user_rst,
    rom_dl_sequencer_if.master sdram,
    output logic               rom_loaded,
    output logic               core_reset,
    output logic               dl_busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] CNT_ONE = {{FIFO_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_LOG2:0] FULL_CNT = CNT_ONE << FIFO_LOG2;
    localparam logic [FIFO_LOG2-1:0] PTR_ONE = CNT_ONE[FIFO_LOG2-1:0];

    logic [32:0]          fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 wr_q;
    logic                 downl_q;
    logic                 load_pending;
    logic [15:0]          rst_cnt;
    state_t               state;
    logic                 sel1;
    logic                 sel2;

    logic        empty;
    logic        full;
    logic        wr_rise;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        drop;
    logic [24:0] head_addr;
    logic [7:0]  head_byte;
    logic [24:0] sp;
    logic [22:0] p1_a;
    logic [1:0]  p1_ds;
    logic [22:0] p2_a;
    logic [1:0]  p2_ds;
    logic [15:0] head_d;
    logic        ack1_ok;
    logic        ack2_ok;
    logic        xfer_done;
    logic        drained;
    logic        dl_fall;
    logic        unused_bits;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign wr_rise   = ioctl_wr & ~wr_q;
    assign push_req  = wr_rise & ioctl_downl & (ioctl_index == DL_INDEX);
    assign pop       = (state == S_IDLE) & ~empty;
    assign push      = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    assign head_addr = fifo_mem[rd_ptr][32:8];
    assign head_byte = fifo_mem[rd_ptr][7:0];
    assign head_d    = {head_byte, head_byte};
    assign sp        = head_addr - SP_BASE;

    assign p1_a      = head_addr[23:1];
    assign p1_ds     = {head_addr[0], ~head_addr[0]};
    assign p2_a      = {sp[23:16], sp[13:0], sp[15]};
    assign p2_ds     = {sp[14], ~sp[14]};

    assign ack1_ok   = ~sel1 | (sdram.port1_ack == sdram.port1_req);
    assign ack2_ok   = ~sel2 | (sdram.port2_ack == sdram.port2_req);
    assign xfer_done = ack1_ok & ack2_ok;

    assign drained   = ~ioctl_downl & empty & (state == S_IDLE);
    assign dl_fall   = downl_q & ~ioctl_downl;
    assign dl_busy   = ioctl_downl | ~empty | (state != S_IDLE);

    assign unused_bits = ^{head_addr[24], sp[24]};

    // Byte FIFO storage; entries are only read while count says they are valid.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
        end
    end

    // Strobe edge detect, FIFO pointers/occupancy and sticky overflow.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            wr_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Transfer FSM: pop a byte, load port registers, toggle req, wait for ack.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            sel1            <= 1'b0;
            sel2            <= 1'b0;
            sdram.port1_req <= sdram.port1_ack;
            sdram.port2_req <= sdram.port2_ack;
            sdram.port1_a   <= '0;
            sdram.port1_ds  <= '0;
            sdram.port1_d   <= '0;
            sdram.port2_a   <= '0;
            sdram.port2_ds  <= '0;
            sdram.port2_d   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
`ifdef DL_BOTH_PORTS_EN
                        sel1           <= 1'b1;
                        sel2           <= 1'b1;
                        sdram.port1_a  <= p1_a;
                        sdram.port1_ds <= p1_ds;
                        sdram.port1_d  <= head_d;
                        sdram.port2_a  <= p2_a;
                        sdram.port2_ds <= p2_ds;
                        sdram.port2_d  <= head_d;
`else
                        unique case (1'b1)
                            (head_addr >= SP_BASE): begin
                                sel1           <= 1'b0;
                                sel2           <= 1'b1;
                                sdram.port2_a  <= p2_a;
                                sdram.port2_ds <= p2_ds;
                                sdram.port2_d  <= head_d;
                            end
                            default: begin
                                sel1           <= 1'b1;
                                sel2           <= 1'b0;
                                sdram.port1_a  <= p1_a;
                                sdram.port1_ds <= p1_ds;
                                sdram.port1_d  <= head_d;
                            end
                        endcase
`endif
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sel1) begin
                        sdram.port1_req <= ~sdram.port1_req;
                    end
                    if (sel2) begin
                        sdram.port2_req <= ~sdram.port2_req;
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (xfer_done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Download completion flag, second-reset counter and registered core reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            downl_q      <= 1'b0;
            load_pending <= 1'b0;
            rom_loaded   <= 1'b0;
            rst_cnt      <= RST_HOLD;
            core_reset   <= 1'b1;
        end else begin
            downl_q <= ioctl_downl;
            if ((load_pending | dl_fall) & drained) begin
                rom_loaded   <= 1'b1;
                load_pending <= 1'b0;
            end else if (dl_fall) begin
                load_pending <= 1'b1;
            end
            if (user_rst | ~rom_loaded) begin
                rst_cnt <= RST_HOLD;
            end else if (rst_cnt != 16'd0) begin
                rst_cnt <= rst_cnt - 16'd1;
            end
            core_reset <= user_rst | ~rom_loaded | (rst_cnt == 16'd1);
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed checks of routing, back-pressure, completion and reset.
// Default build (DL_BOTH_PORTS_EN undefined); second-reset hold shortened via RST_HOLD.
module tb_rom_dl_sequencer;

    localparam logic [15:0] HOLD = 16'h0040;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_rst;
    logic        rom_loaded;
    logic        core_reset;
    logic        dl_busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    rom_dl_sequencer_if sd ();

    always #5 clk_sys = ~clk_sys;

    rom_dl_sequencer #(
        .SP_BASE   (25'h12000),
        .DL_INDEX  (8'h00),
        .FIFO_LOG2 (2),
        .RST_HOLD  (HOLD)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_downl (ioctl_downl),
        .ioctl_index (ioctl_index),
        .ioctl_wr    (ioctl_wr),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .user_rst    (user_rst),
        .sdram       (sd.master),
        .rom_loaded  (rom_loaded),
        .core_reset  (core_reset),
        .dl_busy     (dl_busy),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic pend(input bit p2);
        return p2 ? (sd.port2_req ^ sd.port2_ack) : (sd.port1_req ^ sd.port1_ack);
    endfunction

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        step(1);
        ioctl_wr   = 1'b0;
        step(1);
    endtask

    task automatic ack_port(input bit p2);
        step(1);
        if (p2) sd.port2_ack = sd.port2_req;
        else    sd.port1_ack = sd.port1_req;
        step(1);
    endtask

    task automatic xfer(input string tag, input bit p2, input logic [22:0] a,
                        input logic [1:0] ds, input logic [15:0] d, input bit do_ack);
        int n;
        n = 0;
        while (pend(p2) == 1'b0 && n < 16) begin
            step(1);
            n++;
        end
        chk({tag, "_req"}, 32'(pend(p2)), 32'd1);
        chk({tag, "_a"}, 32'(p2 ? sd.port2_a : sd.port1_a), 32'(a));
        chk({tag, "_ds"}, 32'(p2 ? sd.port2_ds : sd.port1_ds), 32'(ds));
        chk({tag, "_d"}, 32'(p2 ? sd.port2_d : sd.port1_d), 32'(d));
        chk({tag, "_oth"}, 32'(pend(~p2)), 32'd0);
        if (do_ack) ack_port(p2);
    endtask

    task automatic pulse_check(input string tag);
        int n;
        n = 0;
        while (core_reset === 1'b0 && n < 300) begin
            n++;
            step(1);
        end
        chk({tag, "_low"}, 32'(n), 32'(HOLD) - 32'd1);
        chk({tag, "_hi"}, 32'(core_reset), 32'd1);
        step(1);
        chk({tag, "_end"}, 32'(core_reset), 32'd0);
        step(4);
        chk({tag, "_stay"}, 32'(core_reset), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        ioctl_downl  = 1'b0;
        ioctl_index  = 8'h00;
        ioctl_wr     = 1'b0;
        ioctl_addr   = '0;
        ioctl_dout   = '0;
        user_rst     = 1'b0;
        sd.port1_ack = 1'b0;
        sd.port2_ack = 1'b0;
        step(3);

        chk("rst_req1", 32'(sd.port1_req), 32'd0);
        chk("rst_req2", 32'(sd.port2_req), 32'd0);
        chk("rst_a1", 32'(sd.port1_a), 32'd0);
        chk("rst_d2", 32'(sd.port2_d), 32'd0);
        chk("rst_loaded", 32'(rom_loaded), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_core", 32'(core_reset), 32'd1);
        chk("rst_busy", 32'(dl_busy), 32'd0);
        reset_n = 1'b1;
        step(2);

        wr_byte(25'h20, 8'h11);
        step(4);
        chk("t6_nodl", 32'(pend(0)), 32'd0);
        chk("t6_busy0", 32'(dl_busy), 32'd0);
        ioctl_downl = 1'b1;
        ioctl_index = 8'hFF;
        wr_byte(25'h21, 8'h22);
        wr_byte(25'h12010, 8'h33);
        step(4);
        chk("t6_idx1", 32'(pend(0)), 32'd0);
        chk("t6_idx2", 32'(pend(1)), 32'd0);
        ioctl_index = 8'h00;
        step(4);
        chk("t6_empty", 32'(pend(0)), 32'd0);
        chk("t6_busy1", 32'(dl_busy), 32'd1);

        wr_byte(25'h00003, 8'hA5);
        xfer("t1", 1'b0, 23'h000001, 2'b10, 16'hA5A5, 1'b1);
        wr_byte(25'h00004, 8'h12);
        xfer("t1b", 1'b0, 23'h000002, 2'b01, 16'h1212, 1'b1);
        wr_byte(25'h11FFF, 8'h5A);
        xfer("t1e", 1'b0, 23'h008FFF, 2'b10, 16'h5A5A, 1'b1);

        wr_byte(25'h12000, 8'h11);
        xfer("t2b", 1'b1, 23'h000000, 2'b01, 16'h1111, 1'b1);
        wr_byte(25'h1A001, 8'h3C);
        xfer("t2", 1'b1, 23'h000003, 2'b01, 16'h3C3C, 1'b1);
        wr_byte(25'h26002, 8'h77);
        xfer("t2h", 1'b1, 23'h008004, 2'b10, 16'h7777, 1'b1);

        chk("t3_ovf0", 32'(overflow), 32'd0);
        wr_byte(25'h00100, 8'hD0);
        xfer("t3h", 1'b0, 23'h000080, 2'b01, 16'hD0D0, 1'b0);
        for (int i = 0; i < 4; i++) wr_byte(25'h200 + 25'(i), 8'hE0 + 8'(i));
        step(1);
        chk("t3_nofull", 32'(overflow), 32'd0);
        for (int i = 4; i < 6; i++) wr_byte(25'h200 + 25'(i), 8'hE0 + 8'(i));
        step(1);
        chk("t3_ovf1", 32'(overflow), 32'd1);
        step(3);
        chk("t3_stab_a", 32'(sd.port1_a), 32'h80);
        chk("t3_stab_d", 32'(sd.port1_d), 32'hD0D0);
        chk("t3_busy", 32'(dl_busy), 32'd1);
        ack_port(1'b0);
        xfer("t3e0", 1'b0, 23'h000100, 2'b01, 16'hE0E0, 1'b1);
        xfer("t3e1", 1'b0, 23'h000100, 2'b10, 16'hE1E1, 1'b1);
        xfer("t3e2", 1'b0, 23'h000101, 2'b01, 16'hE2E2, 1'b1);
        xfer("t3e3", 1'b0, 23'h000101, 2'b10, 16'hE3E3, 1'b1);
        step(6);
        chk("t3_drop", 32'(pend(0)), 32'd0);
        chk("t3_sticky", 32'(overflow), 32'd1);

        wr_byte(25'h00300, 8'h01);
        xfer("t4a", 1'b0, 23'h000180, 2'b01, 16'h0101, 1'b0);
        wr_byte(25'h00301, 8'h02);
        ioctl_downl = 1'b0;
        step(3);
        chk("t4_nl0", 32'(rom_loaded), 32'd0);
        chk("t4_busy", 32'(dl_busy), 32'd1);
        ack_port(1'b0);
        xfer("t4b", 1'b0, 23'h000180, 2'b10, 16'h0202, 1'b0);
        chk("t4_nl1", 32'(rom_loaded), 32'd0);
        ack_port(1'b0);
        chk("t4_nl2", 32'(rom_loaded), 32'd0);
        chk("t4_idle", 32'(dl_busy), 32'd0);
        step(1);
        chk("t4_loaded", 32'(rom_loaded), 32'd1);
        chk("t4_core1", 32'(core_reset), 32'd1);
        step(1);
        chk("t4_core0", 32'(core_reset), 32'd0);
        pulse_check("t4p");

        user_rst = 1'b1;
        step(1);
        chk("ur_core1", 32'(core_reset), 32'd1);
        user_rst = 1'b0;
        step(1);
        chk("ur_core0", 32'(core_reset), 32'd0);
        pulse_check("urp");

        ioctl_downl = 1'b1;
        wr_byte(25'h00010, 8'h99);
        xfer("t5", 1'b0, 23'h000008, 2'b01, 16'h9999, 1'b0);
        wr_byte(25'h00012, 8'h55);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("t5_req", 32'(pend(0)), 32'd0);
        chk("t5_a", 32'(sd.port1_a), 32'd0);
        chk("t5_d", 32'(sd.port1_d), 32'd0);
        chk("t5_core", 32'(core_reset), 32'd1);
        chk("t5_loaded", 32'(rom_loaded), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        step(8);
        chk("t5_empty1", 32'(pend(0)), 32'd0);
        chk("t5_empty2", 32'(pend(1)), 32'd0);
        ioctl_downl = 1'b0;
        step(1);
        chk("t5_busy", 32'(dl_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
